// File: rtl/rn_ckpt_ctrl_if.sv
// Branch checkpoint bus between the rename stage and rn_ckpt_ctrl.
//   master : rename side, drives branch dispatch / result, observes checkpoint strobes
//   slave  : checkpoint controller, drives save/restore strobes, indices, flush, stall, err
// Signal names keep the controller's point of view (_i into it, _o out of it).
interface rn_ckpt_ctrl_if #(
  parameter int unsigned NUM_CKPT = 4
);
  localparam int unsigned CW = $clog2(NUM_CKPT);

  logic          br_dispatch_i;
  logic          br_result_valid_i;
  logic          br_result_hit_i;
  logic          ckpt_save_o;
  logic [CW-1:0] ckpt_wr_idx_o;
  logic          ckpt_restore_o;
  logic [CW-1:0] ckpt_rd_idx_o;
  logic          flush_o;
  logic          stall_o;
  logic [CW:0]   ckpt_count_o;
  logic          err_o;

  modport master (
    output br_dispatch_i,
    output br_result_valid_i,
    output br_result_hit_i,
    input  ckpt_save_o,
    input  ckpt_wr_idx_o,
    input  ckpt_restore_o,
    input  ckpt_rd_idx_o,
    input  flush_o,
    input  stall_o,
    input  ckpt_count_o,
    input  err_o
  );

  modport slave (
    input  br_dispatch_i,
    input  br_result_valid_i,
    input  br_result_hit_i,
    output ckpt_save_o,
    output ckpt_wr_idx_o,
    output ckpt_restore_o,
    output ckpt_rd_idx_o,
    output flush_o,
    output stall_o,
    output ckpt_count_o,
    output err_o
  );
endinterface

// File: rtl/rn_ckpt_ctrl.sv
// Branch checkpoint controller for the rename stage.
// Allocates one rename-map snapshot slot per renamed branch (FIFO order), frees the oldest
// slot on a correct resolve, and on a mispredict sequences restore+flush then a drain window.
// Ports:
//   clk   : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : rn_ckpt_ctrl_if.slave (dispatch/result in; save/restore/idx/flush/stall/count/err out)
module rn_ckpt_ctrl #(
  parameter int unsigned NUM_CKPT     = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_i,
  rn_ckpt_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_CKPT);
  localparam logic [CW:0] Full = (CW+1)'(NUM_CKPT);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRestore = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    drain_q, drain_d;
  logic          err_q, err_d;

  logic stall;
  logic save;
  logic res_ok;
  logic res_hit;

  // Stall depends on registers only so rename sees it early in the cycle.
  always_comb begin
    stall   = (state_q != StIdle) || (count_q == Full);
    save    = bus.br_dispatch_i && !stall;
    // Results only count in IDLE with something outstanding; anything else is a violation.
    res_ok  = bus.br_result_valid_i && (count_q != '0) && (state_q == StIdle);
    res_hit = res_ok && bus.br_result_hit_i;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    drain_d = drain_q;
    err_d   = err_q;

    if (bus.br_result_valid_i && (count_q == '0)) err_d = 1'b1;
    if (bus.br_dispatch_i && stall) err_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (res_ok && !bus.br_result_hit_i) begin
          // Mispredict: every younger checkpoint dies, including one saved this cycle.
          tail_d  = head_q;
          count_d = '0;
          state_d = StRestore;
        end else begin
          if (save) tail_d = tail_q + CW'(1);
          if (res_hit) head_d = head_q + CW'(1);
          if (save && !res_hit) begin
            count_d = count_q + (CW+1)'(1);
          end else if (!save && res_hit) begin
            count_d = count_q - (CW+1)'(1);
          end
        end
      end
      StRestore: begin
        if (DRAIN_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StDrain;
          drain_d = 4'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.ckpt_save_o    = save;
    bus.ckpt_wr_idx_o  = tail_q;
    bus.ckpt_restore_o = (state_q == StRestore);
    bus.ckpt_rd_idx_o  = head_q;
    bus.flush_o        = (state_q == StRestore);
    bus.stall_o        = stall;
    bus.ckpt_count_o   = count_q;
    bus.err_o          = err_q;
  end
endmodule
